// File: rtl/ahb_dma_ch_seq_if.sv
// rtl/ahb_dma_ch_seq_if.sv - arbiter/engine-facing signal bundle of the DMA channel sequencer
interface ahb_dma_ch_seq_if #(
  parameter int channel_number      = 19,
  parameter int channel_number_bits = $clog2(channel_number),
  parameter int burst_bits          = 8
);
  logic [channel_number-1:0]      req;
  logic [channel_number_bits-1:0] gnt;
  logic [burst_bits-1:0]          burst_len;
  logic                           beat_done;
  logic                           advance;
  logic                           start;
  logic                           busy;
  logic [channel_number_bits-1:0] cur_ch;
  logic [burst_bits-1:0]          beats_left;
  logic [channel_number-1:0]      ch_ack;
  logic                           abort;

  // master: arbiter and transfer engine side; slave: the sequencer itself
  modport master (
    output req, gnt, burst_len, beat_done,
    input  advance, start, busy, cur_ch, beats_left, ch_ack, abort
  );

  modport slave (
    input  req, gnt, burst_len, beat_done,
    output advance, start, busy, cur_ch, beats_left, ch_ack, abort
  );
endinterface

// File: rtl/ahb_dma_ch_seq.sv
// rtl/ahb_dma_ch_seq.sv - per-burst channel sequencer sitting between a channel arbiter and a transfer engine
// Latches the granted channel, counts beats, then rotates the arbiter and waits one cycle for gnt to settle.
module ahb_dma_ch_seq #(
  parameter int channel_number      = 19,
  parameter int channel_number_bits = $clog2(channel_number),
  parameter int burst_bits          = 8
) (
  input logic             clk,
  input logic             rst,
  ahb_dma_ch_seq_if.slave bus
);

  localparam int req_ext_w = 1 << channel_number_bits;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    XFER   = 2'd1,
    ADV    = 2'd2,
    SETTLE = 2'd3
  } state_t;

  state_t state, state_n;

  logic                           advance_q, advance_n;
  logic                           start_q, start_n;
  logic                           busy_q, busy_n;
  logic                           abort_q, abort_n;
  logic [channel_number_bits-1:0] cur_ch_q, cur_ch_n;
  logic [burst_bits-1:0]          left_q, left_n;
  logic [channel_number-1:0]      ch_ack_q, ch_ack_n;

  // Zero-padded to the full index range so an out-of-range gnt reads as "not requesting".
  logic [req_ext_w-1:0]  req_ext;
  logic [burst_bits-1:0] left_dec;
  logic                  last_beat;

  always_comb begin
    req_ext = '0;
    req_ext[channel_number-1:0] = bus.req;
  end

  assign left_dec  = (left_q != '0) ? (left_q - burst_bits'(1)) : '0;
  assign last_beat = (left_q <= burst_bits'(1));

  always_comb begin
    state_n   = state;
    advance_n = 1'b0;
    start_n   = 1'b0;
    abort_n   = 1'b0;
    ch_ack_n  = '0;
    busy_n    = busy_q;
    cur_ch_n  = cur_ch_q;
    left_n    = left_q;

    case (state)
      IDLE: begin
        if (req_ext[bus.gnt]) begin
          start_n  = 1'b1;
          busy_n   = 1'b1;
          cur_ch_n = bus.gnt;
          left_n   = (bus.burst_len == '0) ? burst_bits'(1) : bus.burst_len;
          state_n  = XFER;
        end else if (|bus.req) begin
          state_n = ADV;
        end
      end

      XFER: begin
        // A beat in the same cycle as the request drop is counted before deciding abort.
        if (bus.beat_done) begin
          left_n = left_dec;
          if (last_beat) begin
            for (int i = 0; i < channel_number; i++) begin
              ch_ack_n[i] = (cur_ch_q == channel_number_bits'(i));
            end
            state_n = ADV;
          end else if (!req_ext[cur_ch_q]) begin
            abort_n = 1'b1;
            state_n = ADV;
          end
        end else if (!req_ext[cur_ch_q]) begin
          abort_n = 1'b1;
          state_n = ADV;
        end
      end

      ADV: begin
        advance_n = 1'b1;
        busy_n    = 1'b0;
        state_n   = SETTLE;
      end

      SETTLE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      advance_q <= 1'b0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      abort_q   <= 1'b0;
      cur_ch_q  <= '0;
      left_q    <= '0;
      ch_ack_q  <= '0;
    end else begin
      state     <= state_n;
      advance_q <= advance_n;
      start_q   <= start_n;
      busy_q    <= busy_n;
      abort_q   <= abort_n;
      cur_ch_q  <= cur_ch_n;
      left_q    <= left_n;
      ch_ack_q  <= ch_ack_n;
    end
  end

  assign bus.advance    = advance_q;
  assign bus.start      = start_q;
  assign bus.busy       = busy_q;
  assign bus.abort      = abort_q;
  assign bus.cur_ch     = cur_ch_q;
  assign bus.beats_left = left_q;
  assign bus.ch_ack     = ch_ack_q;

endmodule

// File: tb/tb_ahb_dma_ch_seq.sv
// tb/tb_ahb_dma_ch_seq.sv - vector-table and scoreboard bench for the DMA channel sequencer
module tb_ahb_dma_ch_seq;
  localparam int N  = 19;
  localparam int CB = 5;
  localparam int BB = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ahb_dma_ch_seq_if #(.channel_number(N), .channel_number_bits(CB), .burst_bits(BB)) bus_if ();

  ahb_dma_ch_seq #(.channel_number(N), .channel_number_bits(CB), .burst_bits(BB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct {
    string          name;
    logic           rst;
    logic [N-1:0]   req;
    logic [CB-1:0]  gnt;
    logic [BB-1:0]  bl;
    logic           bd;
    logic           adv;
    logic           st;
    logic           bsy;
    logic           ab;
    logic [CB-1:0]  ch;
    logic [BB-1:0]  left;
    logic [N-1:0]   ack;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void add(string name, int r, int req, int gnt, int bl, int bd,
                              int adv, int st, int bsy, int ab, int ch, int left, int ack);
    vec_t v;
    v.name = name;
    v.rst  = 1'(r);
    v.req  = N'(req);
    v.gnt  = CB'(gnt);
    v.bl   = BB'(bl);
    v.bd   = 1'(bd);
    v.adv  = 1'(adv);
    v.st   = 1'(st);
    v.bsy  = 1'(bsy);
    v.ab   = 1'(ab);
    v.ch   = CB'(ch);
    v.left = BB'(left);
    v.ack  = N'(ack);
    vecs.push_back(v);
  endfunction

  task automatic check_next();
    vec_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_empty: got no expected entry, required one");
    end else begin
      e = sb.pop_front();
      n_cmp++;
      if ({bus_if.advance, bus_if.start, bus_if.busy, bus_if.abort, bus_if.cur_ch, bus_if.beats_left, bus_if.ch_ack}
          !== {e.adv, e.st, e.bsy, e.ab, e.ch, e.left, e.ack}) begin
        n_bad++;
        $display("FAIL %s: got adv=%0b start=%0b busy=%0b abort=%0b ch=%0d left=%0d ack=%h, required adv=%0b start=%0b busy=%0b abort=%0b ch=%0d left=%0d ack=%h",
                 e.name, bus_if.advance, bus_if.start, bus_if.busy, bus_if.abort, bus_if.cur_ch,
                 bus_if.beats_left, bus_if.ch_ack, e.adv, e.st, e.bsy, e.ab, e.ch, e.left, e.ack);
      end
    end
  endtask

  task automatic apply(vec_t v);
    rst              = v.rst;
    bus_if.req       = v.req;
    bus_if.gnt       = v.gnt;
    bus_if.burst_len = v.bl;
    bus_if.beat_done = v.bd;
    sb.push_back(v);
    @(posedge clk);
    #1;
    check_next();
  endtask

  int first_start;
  int second_start;

  initial begin
    rst              = 1'b1;
    bus_if.req       = '0;
    bus_if.gnt       = '0;
    bus_if.burst_len = '0;
    bus_if.beat_done = 1'b0;

    //  name            rst req      gnt bl bd  adv st bsy ab ch left ack
    add("reset",         1, 'h0,      0, 0, 0,  0, 0, 0, 0, 0, 0, 'h0);
    add("reset_hold",    1, 'h08,     3, 4, 1,  0, 0, 0, 0, 0, 0, 'h0);
    add("b33_start",     0, 'h08,     3, 4, 1,  0, 1, 1, 0, 3, 4, 'h0);
    add("b33_beat1",     0, 'h08,     3, 4, 1,  0, 0, 1, 0, 3, 3, 'h0);
    add("b33_beat2",     0, 'h08,     3, 4, 1,  0, 0, 1, 0, 3, 2, 'h0);
    add("b33_beat3",     0, 'h08,     3, 4, 1,  0, 0, 1, 0, 3, 1, 'h0);
    add("b33_beat4",     0, 'h08,     3, 4, 1,  0, 0, 1, 0, 3, 0, 'h08);
    add("b33_adv",       0, 'h08,     3, 4, 1,  1, 0, 0, 0, 3, 0, 'h0);
    add("b33_settle",    0, 'h08,     3, 4, 1,  0, 0, 0, 0, 3, 0, 'h0);
    for (int i = 0; i < 20; i++)
      add("idle_noreq",  0, 'h0,      3, 4, 1,  0, 0, 0, 0, 3, 0, 'h0);
    add("skip_gnt2",     0, 'h10,     2, 4, 0,  0, 0, 0, 0, 3, 0, 'h0);
    add("skip_adv",      0, 'h10,     2, 4, 0,  1, 0, 0, 0, 3, 0, 'h0);
    add("skip_settle",   0, 'h10,     4, 2, 0,  0, 0, 0, 0, 3, 0, 'h0);
    add("ch4_start",     0, 'h10,     4, 2, 0,  0, 1, 1, 0, 4, 2, 'h0);
    add("ch4_gnt_chg",   0, 'h10,     7, 9, 0,  0, 0, 1, 0, 4, 2, 'h0);
    add("ch4_beat1",     0, 'h10,     7, 9, 1,  0, 0, 1, 0, 4, 1, 'h0);
    add("ch4_last",      0, 'h10,     7, 9, 1,  0, 0, 1, 0, 4, 0, 'h10);
    add("ch4_adv",       0, 'h0,      7, 9, 0,  1, 0, 0, 0, 4, 0, 'h0);
    add("ch4_settle",    0, 'h0,      7, 9, 0,  0, 0, 0, 0, 4, 0, 'h0);
    add("c5_start",      0, 'h20,     5, 8, 0,  0, 1, 1, 0, 5, 8, 'h0);
    add("c5_beat1",      0, 'h20,     5, 8, 1,  0, 0, 1, 0, 5, 7, 'h0);
    add("c5_beat2",      0, 'h20,     5, 8, 1,  0, 0, 1, 0, 5, 6, 'h0);
    add("c5_beat3",      0, 'h20,     5, 8, 1,  0, 0, 1, 0, 5, 5, 'h0);
    add("c5_drop",       0, 'h0,      5, 8, 0,  0, 0, 1, 1, 5, 5, 'h0);
    add("c5_adv",        0, 'h0,      5, 8, 0,  1, 0, 0, 0, 5, 5, 'h0);
    add("c5_settle",     0, 'h0,      5, 8, 0,  0, 0, 0, 0, 5, 5, 'h0);
    add("c1_start",      0, 'h02,     1, 2, 0,  0, 1, 1, 0, 1, 2, 'h0);
    add("c1_beat1",      0, 'h02,     1, 2, 1,  0, 0, 1, 0, 1, 1, 'h0);
    add("c1_last_drop",  0, 'h0,      1, 2, 1,  0, 0, 1, 0, 1, 0, 'h02);
    add("c1_adv",        0, 'h0,      1, 2, 0,  1, 0, 0, 0, 1, 0, 'h0);
    add("c1_settle",     0, 'h0,      1, 2, 0,  0, 0, 0, 0, 1, 0, 'h0);
    add("c6_start",      0, 'h40,     6, 3, 0,  0, 1, 1, 0, 6, 3, 'h0);
    add("c6_beat_drop",  0, 'h0,      6, 3, 1,  0, 0, 1, 1, 6, 2, 'h0);
    add("c6_adv_bd",     0, 'h0,      6, 3, 1,  1, 0, 0, 0, 6, 2, 'h0);
    add("c6_settle_bd",  0, 'h0,      6, 3, 1,  0, 0, 0, 0, 6, 2, 'h0);
    add("c0_len0_start", 0, 'h01,     0, 0, 0,  0, 1, 1, 0, 0, 1, 'h0);
    add("c0_len0_beat",  0, 'h01,     0, 0, 1,  0, 0, 1, 0, 0, 0, 'h01);
    add("c0_adv",        0, 'h01,     0, 0, 0,  1, 0, 0, 0, 0, 0, 'h0);
    add("c0_settle",     0, 'h0,      0, 0, 0,  0, 0, 0, 0, 0, 0, 'h0);
    add("c18_start",     0, 'h40000, 18, 1, 0,  0, 1, 1, 0, 18, 1, 'h0);
    add("c18_beat",      0, 'h40000, 18, 1, 1,  0, 0, 1, 0, 18, 0, 'h40000);
    add("c18_adv",       0, 'h0,     18, 1, 0,  1, 0, 0, 0, 18, 0, 'h0);
    add("c18_settle",    0, 'h0,     18, 1, 0,  0, 0, 0, 0, 18, 0, 'h0);
    add("g30_skip",      0, 'h01,    30, 4, 0,  0, 0, 0, 0, 18, 0, 'h0);
    add("g30_adv",       0, 'h01,    30, 4, 0,  1, 0, 0, 0, 18, 0, 'h0);
    add("g30_settle",    0, 'h0,     30, 4, 0,  0, 0, 0, 0, 18, 0, 'h0);
    add("c2_start",      0, 'h04,     2, 5, 0,  0, 1, 1, 0, 2, 5, 'h0);
    add("c2_beat",       0, 'h04,     2, 5, 1,  0, 0, 1, 0, 2, 4, 'h0);
    add("c2_rst_mid",    1, 'h04,     2, 5, 1,  0, 0, 0, 0, 0, 0, 'h0);
    add("c2_restart",    0, 'h04,     2, 3, 0,  0, 1, 1, 0, 2, 3, 'h0);
    add("c2_drop",       0, 'h0,      2, 3, 0,  0, 0, 1, 1, 2, 3, 'h0);
    add("c2_adv",        0, 'h0,      2, 3, 0,  1, 0, 0, 0, 2, 3, 'h0);
    add("c2_settle",     0, 'h0,      2, 3, 0,  0, 0, 0, 0, 2, 3, 'h0);

    foreach (vecs[i]) apply(vecs[i]);

    // Back-to-back bursts with beat_done held high: measure start-to-start spacing.
    rst              = 1'b0;
    bus_if.req       = N'('h08);
    bus_if.gnt       = CB'(3);
    bus_if.burst_len = BB'(4);
    bus_if.beat_done = 1'b1;
    first_start  = -1;
    second_start = -1;
    for (int c = 0; c < 40 && second_start < 0; c++) begin
      @(posedge clk);
      #1;
      if (bus_if.start) begin
        if (first_start < 0) first_start = c;
        else second_start = c;
      end
    end
    n_cmp++;
    if (second_start < 0) begin
      n_bad++;
      $display("FAIL turnaround: got fewer than two starts in 40 cycles, required two");
    end else if (second_start - first_start != 4 + 3) begin
      n_bad++;
      $display("FAIL turnaround: got %0d cycles, required %0d", second_start - first_start, 4 + 3);
    end

    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, required 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
